pico_bcd_port_bank: RTL and testbench
=====================================

Name: pico_bcd_port_bank

Overview:
PicoBlaze-side I/O register bank for the RTC time/date path. It is the counterpart of the combinational port decoder.
- It holds time fields in binary for the processor.
- Processor writes are converted to BCD with a sequential double-dabble and handed to the RTC writer through a req/ack handshake.
- BCD values coming back from the RTC reader are validated, converted to binary and stored.

Parameters:
NUM_REGS, 9, number of time/date fields (sec, min, hr, day, month, year, timer sec/min/hr).
BASE_ID, 8'h00, port_id of field 0; field i sits at BASE_ID+i.
STATUS_ID, 8'h0F, port_id of the status register.
MAX_VAL, 59, largest legal binary field value; max 99.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
port_id  in  8  PicoBlaze port address
out_port  in  8  PicoBlaze write data (binary)
write_strobe  in  1  PicoBlaze write qualifier
read_strobe  in  1  PicoBlaze read qualifier
in_port  out  8  PicoBlaze read data (binary), registered
rtc_wr_req  out  1  BCD write request to RTC writer
rtc_wr_addr  out  4  field index of request
rtc_wr_data  out  8  packed BCD {tens,units}
rtc_wr_ack  in  1  RTC writer accepts request
rtc_rd_valid  in  1  one-cycle BCD update from RTC reader
rtc_rd_addr  in  4  field index of update
rtc_rd_data  in  8  packed BCD {tens,units}

Behaviour:
- Reset (async, reset_n=0):
  - all bin_reg = 0; in_port = 0; rtc_wr_req = 0; rtc_wr_addr = 0; rtc_wr_data = 0.
  - status bits = 0; FSM = IDLE.
  - Asserting reset mid-operation drops rtc_wr_req immediately and abandons the transfer.
- Status register = {4'b0, ovr_err, bin_err, bcd_err, busy}.
  - busy = FSM != IDLE.
  - Error bits are sticky and cleared on the clock after read_strobe with port_id==STATUS_ID. A set event in that same cycle wins.
- in_port is registered each clk from port_id, giving 1-cycle latency (KCPSM3 timing):
  - field range → bin_reg[port_id-BASE_ID];
  - STATUS_ID → status;
  - anything else → 8'h00.
- FSM states and transitions:
  - IDLE: write_strobe with port_id in field range.
    - If out_port > MAX_VAL: set bin_err, stay IDLE.
    - Otherwise latch value and index, go to CONV.
  - CONV: 8 cycles of shift-add-3 (add 3 to any nibble ≥5 before each shift), then go to REQ.
  - REQ: rtc_wr_req=1 with rtc_wr_addr and rtc_wr_data held stable. On the first clk with rtc_wr_ack=1: bin_reg[idx] ← latched value, rtc_wr_req=0, go to IDLE.
- Write latency: write_strobe sampled at cycle 0 → rtc_wr_req high from cycle 9 → one cycle after ack, request low and busy=0.
- write_strobe to the field range while busy: dropped, ovr_err set, in-flight transfer unaffected.
- write_strobe to STATUS_ID or an unmapped id: ignored.
- rtc_rd_valid with rtc_rd_addr < NUM_REGS:
  - If both nibbles ≤9 and tens*10+units ≤ MAX_VAL: bin_reg[addr] ← tens*8 + tens*2 + units on the next clk.
  - Otherwise bcd_err is set and the register is unchanged.
  - Addresses ≥ NUM_REGS are ignored.
- Collision: rtc_rd_valid on the same index as an ack-cycle write completion → the write value wins.
- Arithmetic: all 8-bit unsigned. The double-dabble shift register is 16 bits {bcd[7:0], bin[7:0]}, so no overflow for inputs ≤99.

Decomposition:
- Shared package pico_rtc_pkg holds:
  - port ID constants: BASE_ID, STATUS_ID;
  - status bit positions: BUSY, BCD_ERR, BIN_ERR, OVR_ERR;
  - field index constants: SEC..TMR_HR;
  - FSM state encoding: IDLE, CONV, REQ.
- Sub-module bin2bcd_seq: start/done, 8-cycle double-dabble, 8-bit in → 8-bit packed BCD out. It is instantiated once in CONV.

Test Plan:
- Write 8'd45 to port 8'h01 → rtc_wr_req rises at cycle 9 with addr 1 and data 8'h45. Hold ack 0 for 3 cycles: req, addr and data stay stable. Ack → req low next cycle; reading port 8'h01 returns 8'h2D.
- rtc_rd_valid, addr 2, data 8'h37 → read port 8'h02 returns 8'h25. Data 8'h3A → bcd_err=1, reg stays 8'h25; status read returns 8'h02, and a second read returns 8'h00.
- Write 8'd60 → no rtc_wr_req, status = 8'h04. Write 8'd59 → data 8'h59; write 8'd0 → data 8'h00.
- Write 8'd12 then 8'd30 two cycles later → one request with data 8'h12, ovr_err set, busy=1 until ack.
- Same-index rtc_rd_valid (8'h10) in the ack cycle of a write of 8'd22 → reg reads 8'h16.
- reset_n low during REQ → rtc_wr_req low asynchronously (before the next clk edge); all regs and status read 8'h00 after release.

Source files
------------

// File: rtl/pico_rtc_pkg.sv
// Shared constants, state encoding and BCD helper for the PicoBlaze RTC port bank.
package pico_rtc_pkg;

  localparam logic [7:0] BASE_ID   = 8'h00;
  localparam logic [7:0] STATUS_ID = 8'h0F;

  localparam int BUSY    = 0;
  localparam int BCD_ERR = 1;
  localparam int BIN_ERR = 2;
  localparam int OVR_ERR = 3;

  localparam logic [3:0] SEC     = 4'd0;
  localparam logic [3:0] MIN     = 4'd1;
  localparam logic [3:0] HR      = 4'd2;
  localparam logic [3:0] DAY     = 4'd3;
  localparam logic [3:0] MONTH   = 4'd4;
  localparam logic [3:0] YEAR    = 4'd5;
  localparam logic [3:0] TMR_SEC = 4'd6;
  localparam logic [3:0] TMR_MIN = 4'd7;
  localparam logic [3:0] TMR_HR  = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    REQ  = 2'd2
  } state_e;

  // tens*10 + units built from shifts so no multiplier is inferred
  function automatic logic [7:0] bcd_to_bin(input logic [7:0] bcd);
    return {1'b0, bcd[7:4], 3'b000} + {3'b000, bcd[7:4], 1'b0} + {4'b0000, bcd[3:0]};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 8-bit binary in, packed two-digit BCD out after 8 shifts.
module bin2bcd_seq (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] din,
  output logic       done,
  output logic [7:0] dout
);

  logic [15:0] r_sr;
  logic [3:0]  r_cnt;
  logic        r_done;

  function automatic logic [15:0] dabble_step(input logic [15:0] sr);
    logic [15:0] t;
    t = sr;
    if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
    if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
    return {t[14:0], 1'b0};
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sr   <= 16'h0000;
      r_cnt  <= 4'd0;
      r_done <= 1'b0;
    end else if (start) begin
      r_sr   <= {8'h00, din};
      r_cnt  <= 4'd8;
      r_done <= 1'b0;
    end else if (r_cnt != 4'd0) begin
      r_sr   <= dabble_step(r_sr);
      r_cnt  <= r_cnt - 4'd1;
      r_done <= (r_cnt == 4'd1);
    end else begin
      r_done <= 1'b0;
    end
  end

  assign done = r_done;
  assign dout = r_sr[15:8];

endmodule

// File: rtl/pico_bcd_port_bank.sv
// PicoBlaze I/O bank holding binary time fields; writes go to the RTC as BCD via req/ack,
// BCD updates from the RTC reader are validated and stored as binary.
module pico_bcd_port_bank #(
  parameter int         NUM_REGS  = 9,
  parameter logic [7:0] BASE_ID   = 8'h00,
  parameter logic [7:0] STATUS_ID = 8'h0F,
  parameter logic [7:0] MAX_VAL   = 8'd59
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  input  logic       read_strobe,
  output logic [7:0] in_port,
  output logic       rtc_wr_req,
  output logic [3:0] rtc_wr_addr,
  output logic [7:0] rtc_wr_data,
  input  logic       rtc_wr_ack,
  input  logic       rtc_rd_valid,
  input  logic [3:0] rtc_rd_addr,
  input  logic [7:0] rtc_rd_data
);

  import pico_rtc_pkg::*;

  localparam logic [7:0] NREGS = 8'(NUM_REGS);

  state_e     r_state, w_next;
  logic [7:0] r_bin [NUM_REGS];
  logic [7:0] r_val, r_wr_data, r_in_port;
  logic [3:0] r_idx;
  logic       r_bcd_err, r_bin_err, r_ovr_err;

  logic [7:0] w_off, w_rd_bin, w_status, w_rd_mux, w_bcd;
  logic       w_wr_hit, w_rd_hit, w_rd_ok, w_start, w_commit, w_conv_done;
  logic       w_stat_rd, w_bin_set, w_ovr_set, w_bcd_set;

  assign w_off     = port_id - BASE_ID;
  assign w_wr_hit  = write_strobe && (w_off < NREGS);
  assign w_rd_hit  = rtc_rd_valid && ({4'h0, rtc_rd_addr} < NREGS);
  assign w_rd_bin  = bcd_to_bin(rtc_rd_data);
  assign w_rd_ok   = (rtc_rd_data[7:4] <= 4'd9) && (rtc_rd_data[3:0] <= 4'd9) &&
                     (w_rd_bin <= MAX_VAL);
  assign w_stat_rd = read_strobe && (port_id == STATUS_ID);
  assign w_bin_set = (r_state == IDLE) && w_wr_hit && (out_port > MAX_VAL);
  assign w_ovr_set = (r_state != IDLE) && w_wr_hit;
  assign w_bcd_set = w_rd_hit && !w_rd_ok;

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (w_start),
    .din     (out_port),
    .done    (w_conv_done),
    .dout    (w_bcd)
  );

  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      IDLE: if (w_wr_hit && (out_port <= MAX_VAL)) begin
        w_start = 1'b1;
        w_next  = CONV;
      end
      CONV: if (w_conv_done) w_next = REQ;
      REQ:  if (rtc_wr_ack) begin
        w_commit = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_status          = 8'h00;
    w_status[BUSY]    = (r_state != IDLE);
    w_status[BCD_ERR] = r_bcd_err;
    w_status[BIN_ERR] = r_bin_err;
    w_status[OVR_ERR] = r_ovr_err;
  end

  always_comb begin
    w_rd_mux = 8'h00;
    if (w_off < NREGS)            w_rd_mux = r_bin[w_off[3:0]];
    else if (port_id == STATUS_ID) w_rd_mux = w_status;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_val     <= 8'h00;
      r_idx     <= 4'h0;
      r_wr_data <= 8'h00;
      r_in_port <= 8'h00;
      r_bcd_err <= 1'b0;
      r_bin_err <= 1'b0;
      r_ovr_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_val <= out_port;
        r_idx <= w_off[3:0];
      end
      if ((r_state == CONV) && w_conv_done) r_wr_data <= w_bcd;
      r_in_port <= w_rd_mux;
      // a set event in the clearing cycle keeps the bit set
      r_bcd_err <= w_bcd_set | (r_bcd_err & ~w_stat_rd);
      r_bin_err <= w_bin_set | (r_bin_err & ~w_stat_rd);
      r_ovr_err <= w_ovr_set | (r_ovr_err & ~w_stat_rd);
    end
  end

  // processor write completion is ordered last so it wins a same-index RTC update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_bin[i] <= 8'h00;
    end else begin
      if (w_rd_hit && w_rd_ok) r_bin[rtc_rd_addr] <= w_rd_bin;
      if (w_commit)            r_bin[r_idx]       <= r_val;
    end
  end

  assign in_port     = r_in_port;
  assign rtc_wr_req  = (r_state == REQ);
  assign rtc_wr_addr = r_idx;
  assign rtc_wr_data = r_wr_data;

endmodule

// File: tb/tb_pico_bcd_port_bank.sv
// Scoreboard bench for pico_bcd_port_bank: expected RTC write requests queued at stimulus time.
module tb_pico_bcd_port_bank;
  import pico_rtc_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] port_id, out_port;
  logic       write_strobe, read_strobe;
  logic [7:0] in_port;
  logic       rtc_wr_req;
  logic [3:0] rtc_wr_addr;
  logic [7:0] rtc_wr_data;
  logic       rtc_wr_ack, rtc_rd_valid;
  logic [3:0] rtc_rd_addr;
  logic [7:0] rtc_rd_data;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] bcd;
    logic [7:0] bin;
  } wr_t;

  wr_t exp_q[$];
  wr_t cur;

  pico_bcd_port_bank dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .port_id      (port_id),
    .out_port     (out_port),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .in_port      (in_port),
    .rtc_wr_req   (rtc_wr_req),
    .rtc_wr_addr  (rtc_wr_addr),
    .rtc_wr_data  (rtc_wr_data),
    .rtc_wr_ack   (rtc_wr_ack),
    .rtc_rd_valid (rtc_rd_valid),
    .rtc_rd_addr  (rtc_rd_addr),
    .rtc_rd_data  (rtc_rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic drive_write(input logic [7:0] id, input logic [7:0] v, input bit expect_req);
    wr_t w;
    port_id      = id;
    out_port     = v;
    write_strobe = 1'b1;
    if (expect_req) begin
      w.addr = id[3:0];
      w.bcd  = to_bcd(int'(v));
      w.bin  = v;
      exp_q.push_back(w);
    end
    tick();
    write_strobe = 1'b0;
    port_id      = 8'h0E;
  endtask

  task automatic read_port(input logic [7:0] id, output logic [7:0] v);
    port_id     = id;
    read_strobe = 1'b1;
    tick();
    read_strobe = 1'b0;
    v           = in_port;
  endtask

  task automatic rtc_update(input logic [3:0] a, input logic [7:0] d);
    rtc_rd_valid = 1'b1;
    rtc_rd_addr  = a;
    rtc_rd_data  = d;
    tick();
    rtc_rd_valid = 1'b0;
  endtask

  task automatic wait_req(output int lat);
    lat = 0;
    while (rtc_wr_req !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
    checks++;
    if (rtc_wr_req !== 1'b1) begin
      errors++;
      $display("FAIL req_timeout: rtc_wr_req=%b after %0d cycles, want 1", rtc_wr_req, lat);
    end else if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL req_unexpected: addr=%h data=%h, want no request", rtc_wr_addr, rtc_wr_data);
    end else begin
      cur = exp_q.pop_front();
      if ({rtc_wr_addr, rtc_wr_data} !== {cur.addr, cur.bcd}) begin
        errors++;
        $display("FAIL req_payload: addr=%h data=%h, want addr=%h data=%h",
                 rtc_wr_addr, rtc_wr_data, cur.addr, cur.bcd);
      end
    end
  endtask

  task automatic ack_req();
    rtc_wr_ack = 1'b1;
    tick();
    rtc_wr_ack = 1'b0;
    checks++;
    if (rtc_wr_req !== 1'b0) begin
      errors++;
      $display("FAIL req_after_ack: rtc_wr_req=%b, want 0", rtc_wr_req);
    end
  endtask

  task automatic no_req_window(input string name);
    bit seen = 1'b0;
    repeat (14) begin
      tick();
      if (rtc_wr_req !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL %s: rtc_wr_req seen=1, want 0", name);
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({rtc_wr_req, rtc_wr_addr, rtc_wr_data, in_port} !== 21'h0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b addr=%h data=%h in=%h, want all 0",
               rtc_wr_req, rtc_wr_addr, rtc_wr_data, in_port);
    end
    reset_n = 1'b1;
    tick();
    read_port(STATUS_ID, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL reset_status: got %h want 00", v); end
    read_port(BASE_ID + 8'(SEC), v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL reset_sec: got %h want 00", v); end
  endtask

  task automatic test_write_45();
    int lat;
    logic [7:0] v;
    drive_write(8'h01, 8'd45, 1'b1);
    wait_req(lat);
    checks++;
    if (lat != 9) begin errors++; $display("FAIL wr_latency: got %0d want 9", lat); end
    repeat (3) begin
      tick();
      checks++;
      if ({rtc_wr_req, rtc_wr_addr, rtc_wr_data} !== {1'b1, 4'h1, 8'h45}) begin
        errors++;
        $display("FAIL req_hold: req=%b addr=%h data=%h, want 1/1/45",
                 rtc_wr_req, rtc_wr_addr, rtc_wr_data);
      end
    end
    read_port(STATUS_ID, v);
    checks++;
    if (v !== 8'h01) begin errors++; $display("FAIL busy_status: got %h want 01", v); end
    ack_req();
    read_port(STATUS_ID, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL idle_status: got %h want 00", v); end
    read_port(8'h01, v);
    checks++;
    if (v !== 8'h2D) begin errors++; $display("FAIL read_min: got %h want 2D", v); end
  endtask

  task automatic test_rtc_update();
    logic [7:0] v;
    rtc_update(4'd2, 8'h37);
    read_port(8'h02, v);
    checks++;
    if (v !== 8'h25) begin errors++; $display("FAIL rd_update: got %h want 25", v); end
    rtc_update(4'd2, 8'h3A);
    read_port(8'h02, v);
    checks++;
    if (v !== 8'h25) begin errors++; $display("FAIL rd_bad_keep: got %h want 25", v); end
    rtc_update(4'd3, 8'h60);
    read_port(8'h03, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL rd_over_max: got %h want 00", v); end
    read_port(STATUS_ID, v);
    checks++;
    if (v !== 8'h02) begin errors++; $display("FAIL bcd_err_status: got %h want 02", v); end
    read_port(STATUS_ID, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL bcd_err_clear: got %h want 00", v); end
  endtask

  task automatic test_bin_range();
    int lat;
    logic [7:0] v;
    drive_write(8'h03, 8'd60, 1'b0);
    no_req_window("no_req_60");
    read_port(STATUS_ID, v);
    checks++;
    if (v !== 8'h04) begin errors++; $display("FAIL bin_err_status: got %h want 04", v); end
    read_port(STATUS_ID, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL bin_err_clear: got %h want 00", v); end
    drive_write(8'h00, 8'd59, 1'b1);
    wait_req(lat);
    ack_req();
    drive_write(8'h05, 8'd0, 1'b1);
    wait_req(lat);
    ack_req();
    read_port(8'h00, v);
    checks++;
    if (v !== 8'd59) begin errors++; $display("FAIL read_59: got %h want 3B", v); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [7:0] v;
    drive_write(8'h04, 8'd12, 1'b1);
    tick();
    drive_write(8'h04, 8'd30, 1'b0);
    wait_req(lat);
    checks++;
    if (lat != 7) begin errors++; $display("FAIL b2b_latency: got %0d want 7", lat); end
    read_port(STATUS_ID, v);
    checks++;
    if (v !== 8'h09) begin errors++; $display("FAIL ovr_status: got %h want 09", v); end
    ack_req();
    read_port(STATUS_ID, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL ovr_clear: got %h want 00", v); end
    read_port(8'h04, v);
    checks++;
    if (v !== 8'h0C) begin errors++; $display("FAIL read_12: got %h want 0C", v); end
    no_req_window("b2b_single_req");
  endtask

  task automatic test_collision();
    int lat;
    logic [7:0] v;
    drive_write(8'h06, 8'd22, 1'b1);
    wait_req(lat);
    rtc_wr_ack   = 1'b1;
    rtc_rd_valid = 1'b1;
    rtc_rd_addr  = 4'd6;
    rtc_rd_data  = 8'h10;
    tick();
    rtc_wr_ack   = 1'b0;
    rtc_rd_valid = 1'b0;
    read_port(8'h06, v);
    checks++;
    if (v !== 8'h16) begin errors++; $display("FAIL collision: got %h want 16", v); end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [7:0] v;
    drive_write(8'h07, 8'd33, 1'b1);
    wait_req(lat);
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (rtc_wr_req !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_req: got %b want 0", rtc_wr_req);
    end
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      read_port(BASE_ID + 8'(i), v);
      checks++;
      if (v !== 8'h00) begin errors++; $display("FAIL post_reset_reg%0d: got %h want 00", i, v); end
    end
    read_port(STATUS_ID, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL post_reset_status: got %h want 00", v); end
    no_req_window("abandoned_req");
  endtask

  initial begin
    port_id      = 8'h0E;
    out_port     = 8'h00;
    write_strobe = 1'b0;
    read_strobe  = 1'b0;
    rtc_wr_ack   = 1'b0;
    rtc_rd_valid = 1'b0;
    rtc_rd_addr  = 4'h0;
    rtc_rd_data  = 8'h00;
    reset_n      = 1'b0;
    test_reset();
    test_write_45();
    test_rtc_update();
    test_bin_range();
    test_back_to_back();
    test_collision();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expect: %0d queued, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
